// File: rtl/jt49_mix_dcrm.sv
// jt49_mix_dcrm: output stage for the PSG.
// It weights channels A/B/C by their 4-bit gains and sums them with a single
// shared multiplier. A moving-average DC estimate is then subtracted, and the
// result is emitted as a signed 16-bit sample with a one-cycle valid pulse.
module jt49_mix_dcrm #(
  parameter int AVG_LOG2 = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [7:0]  C,
  input  logic [3:0]  gainA,
  input  logic [3:0]  gainB,
  input  logic [3:0]  gainC,
  output logic [15:0] sample,
  output logic        sample_vld,
  output logic        busy,
  output logic        overrun
);

  localparam int DATA_W = 8;
  localparam int COEF_W = 4;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int SUM_W  = 14;
  localparam int ACC_W  = SUM_W + AVG_LOG2;
  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam logic [AVG_LOG2:0] FILL_FULL = (AVG_LOG2+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MULA = 3'd1,
    MULB = 3'd2,
    MULC = 3'd3,
    AVG  = 3'd4,
    OUT  = 3'd5
  } state_t;

  state_t state, state_nxt;

  // Holding registers: the inputs are captured only when a request is accepted.
  logic [DATA_W-1:0] a_l, b_l, c_l;
  logic [COEF_W-1:0] ga_l, gb_l, gc_l;

  // Multiplier operands and running sum.
  logic [DATA_W-1:0] mul_x;
  logic [COEF_W-1:0] mul_g;
  logic [PROD_W-1:0] prod;
  logic [SUM_W-1:0]  sum;

  // DC estimator state.
  logic [ACC_W-1:0]    acc;
  logic [AVG_LOG2-1:0] wr_ptr;
  logic [AVG_LOG2:0]   fill;
  logic [SUM_W-1:0]    dc_buf [DEPTH];
  logic [SUM_W-1:0]    old_val;
  logic [SUM_W-1:0]    mean;

  // Remove the DC estimate from the mixed sum.
  // Both operands are at most 14 bits wide, so the 16-bit signed difference
  // cannot wrap.
  function automatic logic signed [15:0] dc_remove(input logic [SUM_W-1:0] s,
                                                   input logic [SUM_W-1:0] m);
    logic signed [15:0] se;
    logic signed [15:0] me;
    se = signed'(16'(s));
    me = signed'(16'(m));
    return se - me;
  endfunction

  assign busy = (state != IDLE);

  // The oldest entry leaves the window only once the window has filled.
  // Until then the buffer can hold stale data, so that data is masked to zero.
  assign old_val = (fill == FILL_FULL) ? dc_buf[wr_ptr] : '0;
  assign mean    = acc[ACC_W-1:AVG_LOG2];

  // Steer the shared multiplier to the channel that the current state handles.
  always_comb begin
    mul_x = a_l;
    mul_g = ga_l;
    case (state)
      MULB: begin
        mul_x = b_l;
        mul_g = gb_l;
      end
      MULC: begin
        mul_x = c_l;
        mul_g = gc_l;
      end
      default: ;
    endcase
  end

  assign prod = PROD_W'(mul_x) * PROD_W'(mul_g);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state sequencing: one sample walks through every state exactly once.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cen) state_nxt = MULA;
      MULA:    state_nxt = MULB;
      MULB:    state_nxt = MULC;
      MULC:    state_nxt = AVG;
      AVG:     state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture channel levels and gains when a request is accepted.
  always_ff @(posedge clk) begin
    if (state == IDLE && cen) begin
      a_l  <= A;
      b_l  <= B;
      c_l  <= C;
      ga_l <= gainA;
      gb_l <= gainB;
      gc_l <= gainC;
    end
  end

  // Window history; fill masks its stale contents, so it is left unreset.
  always_ff @(posedge clk) begin
    if (state == AVG) dc_buf[wr_ptr] <= sum;
  end

  // Accumulate the mix, update the DC estimate and emit the sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum        <= '0;
      acc        <= '0;
      wr_ptr     <= '0;
      fill       <= '0;
      sample     <= '0;
      sample_vld <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (busy && cen) overrun <= 1'b1;
      case (state)
        MULA: sum <= SUM_W'(prod);
        MULB: sum <= sum + SUM_W'(prod);
        MULC: sum <= sum + SUM_W'(prod);
        AVG: begin
          sample     <= dc_remove(sum, mean);
          sample_vld <= 1'b1;
          acc        <= acc + ACC_W'(sum) - ACC_W'(old_val);
          wr_ptr     <= wr_ptr + 1'b1;
          if (fill != FILL_FULL) fill <= fill + 1'b1;
        end
        OUT: sample_vld <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
